// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and helpers for the round-robin stream mux.
package stream_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr.
module rr_arbiter #(
  parameter int N_IN = 4,
  parameter int SW = 2
) (
  input  logic [N_IN-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_IN-1:0] grant,
  output logic [SW-1:0]   idx
);
  logic [SW-1:0] j;
  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      j = SW'((int'(ptr) + k) % N_IN);
      if (req[j]) begin
        grant = N_IN'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux with round-robin arbitration,
// packet locking and a registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W = 4,
  parameter int SW = idx_w(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN-1:0][W-1:0] in_data,
  input  logic [N_IN-1:0]        in_last,
  output logic [N_IN-1:0]        in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic [SW-1:0]          out_sel,
  input  logic                   out_ready
);
  state_e state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, lock_q, lock_d, sel_q, sel_d;
  logic [SW-1:0] arb_idx, g, g_next;
  logic [N_IN-1:0] arb_grant, grant_oh;
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  logic locked, load_en, accept;
  rr_arbiter #(.N_IN(N_IN), .SW(SW)) u_arb (
    .req  (in_valid),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx)
  );
  assign locked   = state_q == LOCKED;
  assign g        = locked ? lock_q : arb_idx;
  assign grant_oh = locked ? (N_IN'(1) << lock_q) : arb_grant;
  assign load_en  = !valid_q || out_ready;
  // No handshake is offered while reset is held.
  assign in_ready = (load_en && !rst) ? grant_oh : '0;
  assign accept   = |(in_ready & in_valid);
  assign g_next   = (g == SW'(N_IN - 1)) ? '0 : g + SW'(1);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data[g];
      last_d  = in_last[g];
      sel_d   = g;
      state_d = in_last[g] ? IDLE : LOCKED;
      lock_d  = in_last[g] ? lock_q : g;
      ptr_d   = in_last[g] ? g_next : ptr_q;
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenarios for stream_mux_rr with N_IN=4, W=4.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0][3:0] in_data = '0;
  logic [3:0] in_last = '0;
  logic [3:0] in_ready;
  logic out_valid, out_last, out_ready = 1'b1;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  int n_checks = 0;
  int n_fail = 0;
  stream_mux_rr #(.N_IN(4), .W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
    end
    rst = 1'b0; #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h0) begin n_fail++; $display("FAIL reset_first_beat: got v=%b sel=%0d d=%h want v=1 sel=0 d=0", out_valid, out_sel, out_data); end
  endtask
  task automatic test_round_robin;
    do_reset();
    in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i);
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 4'(k % 4)) begin n_fail++; $display("FAIL rr_beat%0d: got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h", k, out_valid, out_sel, out_data, k % 4, k % 4); end
    end
  endtask
  task automatic test_packet_lock;
    do_reset();
    in_data[0] = 4'h1; in_data[1] = 4'h2; in_data[3] = 4'h4;
    in_valid = 4'b0100; in_last = 4'b0000; in_data[2] = 4'hA;
    tick();
    n_checks++; if (out_sel !== 2'd2 || out_data !== 4'hA || out_last !== 1'b0) begin n_fail++; $display("FAIL lock_beat1: got sel=%0d d=%h l=%b want sel=2 d=a l=0", out_sel, out_data, out_last); end
    in_valid = 4'hF; in_data[2] = 4'hB;
    #1;
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_ready: got %b want 0100", in_ready); end
    tick();
    n_checks++; if (out_sel !== 2'd2 || out_data !== 4'hB) begin n_fail++; $display("FAIL lock_beat2: got sel=%0d d=%h want sel=2 d=b", out_sel, out_data); end
    in_valid = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_gap_ready%0d: got %b want 0100", c, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lock_gap_valid%0d: got %b want 0", c, out_valid); end
    end
    in_valid = 4'hF; in_data[2] = 4'hC; in_last = 4'b0100;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hC || out_last !== 1'b1) begin n_fail++; $display("FAIL lock_beat3: got v=%b sel=%0d d=%h l=%b want v=1 sel=2 d=c l=1", out_valid, out_sel, out_data, out_last); end
    in_last = 4'hF;
    tick();
    n_checks++; if (out_sel !== 2'd3 || out_data !== 4'h4) begin n_fail++; $display("FAIL lock_next: got sel=%0d d=%h want sel=3 d=4", out_sel, out_data); end
  endtask
  task automatic test_backpressure;
    do_reset();
    in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 8);
    tick();
    n_checks++; if (out_sel !== 2'd0 || out_data !== 4'h8) begin n_fail++; $display("FAIL bp_first: got sel=%0d d=%h want sel=0 d=8", out_sel, out_data); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0000", c, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h8) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b sel=%0d d=%h want v=1 sel=0 d=8", c, out_valid, out_sel, out_data); end
    end
    out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0010", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h9) begin n_fail++; $display("FAIL bp_release: got v=%b sel=%0d d=%h want v=1 sel=1 d=9", out_valid, out_sel, out_data); end
  endtask
  task automatic test_wrap_sparse;
    logic [1:0] exp_sel [3];
    exp_sel[0] = 2'd3; exp_sel[1] = 2'd1; exp_sel[2] = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 4);
    in_valid = 4'b0010; in_last = 4'hF;
    tick();
    n_checks++; if (out_sel !== 2'd1) begin n_fail++; $display("FAIL wrap_setup: got sel=%0d want 1", out_sel); end
    in_valid = 4'b0000;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got v=%b want 0", out_valid); end
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel[k]) begin n_fail++; $display("FAIL wrap_beat%0d: got v=%b sel=%0d want v=1 sel=%0d", k, out_valid, out_sel, exp_sel[k]); end
    end
  endtask
  task automatic test_reset_mid_packet;
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 12);
    in_valid = 4'b0010; in_last = 4'b0000;
    tick();
    in_valid = 4'hF; #1;
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rmp_locked: got %b want 0010", in_ready); end
    rst = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL rmp_in_reset: got v=%b rdy=%b want v=0 rdy=0000", out_valid, in_ready); end
    rst = 1'b0; #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmp_after_ready: got %b want 0001", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hC) begin n_fail++; $display("FAIL rmp_after_beat: got v=%b sel=%0d d=%h want v=1 sel=0 d=c", out_valid, out_sel, out_data); end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap_sparse();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
